instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of instructionmemory. Owns the program counter.

---
 rtl/instruction_fetch_pkg.sv | 17 +
 rtl/instruction_fetch_if.sv | 13 +
 rtl/instruction_fetch.sv | 69 ++++++
 tb/tb_instruction_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage: instruction width, default PC width and the NOP
// encoding loaded into the decode slot on reset and on flush.
package instruction_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int AW_DEFAULT = 9;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } slot_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode pipeline slot: valid/ready handshake carrying the instruction and its word PC.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory combinationally and holds one
// registered slot towards decode. Redirects from execute flush the slot and reload the PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int             AW       = AW_DEFAULT,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [XLEN-1:0]     imem_rd,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  output logic [XLEN-1:0]     fetch_count,
  instruction_fetch_if.master dec
);

  logic [AW-1:0]   pc;
  slot_t           slot;
  logic [XLEN-1:0] count;
  logic            handshake;
  logic            adv;

  assign handshake = slot.valid & dec.if_ready;
  assign adv       = fetch_en & (~slot.valid | dec.if_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      slot  <= '{valid: 1'b0, instr: NOP, pc: '0};
      count <= '0;
    end else begin
      // The handshake completes even when a redirect flushes the slot in the same cycle.
      if (handshake) begin
        count <= count + 1'b1;
      end

      if (redirect_valid) begin
        pc         <= redirect_target[AW-1:0];
        slot.valid <= 1'b0;
        slot.instr <= NOP;
      end else if (adv) begin
        slot.valid <= 1'b1;
        slot.instr <= imem_rd;
        slot.pc    <= XLEN'(pc);
        pc         <= pc + AW'(1);
      end else if (handshake) begin
        // fetch_en low: the accepted slot drains and nothing replaces it.
        slot.valid <= 1'b0;
      end
    end
  end

  assign imem_addr    = XLEN'(pc);
  assign dec.if_valid = slot.valid;
  assign dec.if_instr = slot.instr;
  assign dec.if_pc    = slot.pc;
  assign fetch_count  = count;

  generate
    if (AW < XLEN) begin : g_target_hi
      logic unused_target_hi;
      assign unused_target_hi = ^redirect_target[XLEN-1:AW];
    end
  endgenerate

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected accepts are queued by the stimulus and popped
// by a monitor on every valid&ready; point checks cover reset, stall, flush, wrap and drain.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] fetch_count;

  instruction_fetch_if ifc ();

  instruction_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_count     (fetch_count),
    .dec             (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'd0:   mem = 32'h0000_0000;
      32'd1:   mem = 32'h0000_0113;
      32'd2:   mem = 32'h0040_0093;
      32'd4:   mem = 32'hFE20_AF23;
      32'd5:   mem = 32'hFE30_AFA3;
      32'd87:  mem = 32'h0020_2303;
      default: mem = 32'hA000_0000 | a;
    endcase
  endfunction

  assign imem_rd = mem(imem_addr);

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] max_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back({pc, mem(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the head of the expectation queue.
  always @(negedge clk) begin
    if (imem_addr > max_addr) max_addr = imem_addr;
    if (rst_n && ifc.if_valid && ifc.if_ready) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_accept: got pc %0d instr %h, expected none", ifc.if_pc, ifc.if_instr);
      end else begin
        e = exp_q.pop_front();
        check("accept_pc", ifc.if_pc, e[63:32]);
        check("accept_instr", ifc.if_instr, e[31:0]);
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    ifc.if_ready    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    step();
    step();
    check("rst_valid", 32'(ifc.if_valid), 32'd0);
    check("rst_instr", ifc.if_instr, NOP);
    check("rst_pc", ifc.if_pc, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // Sequential fetch from reset
    rst_n        = 1'b1;
    fetch_en     = 1'b1;
    ifc.if_ready = 1'b1;
    for (int a = 0; a < 4; a++) push(32'(a));
    repeat (5) step();

    // Stall with pc=4 in the slot
    ifc.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(ifc.if_valid), 32'd1);
      check("stall_pc", ifc.if_pc, 32'd4);
      check("stall_instr", ifc.if_instr, 32'hFE20_AF23);
      check("stall_addr", imem_addr, 32'd5);
      step();
    end
    push(32'd4);
    push(32'd5);
    ifc.if_ready = 1'b1;
    step();
    check("nobubble_valid", 32'(ifc.if_valid), 32'd1);
    check("nobubble_pc", ifc.if_pc, 32'd5);
    check("count_after_stall", fetch_count, 32'd5);

    // Redirect to 105 concurrent with accepting pc=5
    redirect_valid  = 1'b1;
    redirect_target = 32'd105;
    step();
    redirect_valid = 1'b0;
    check("flush105_valid", 32'(ifc.if_valid), 32'd0);
    check("flush105_instr", ifc.if_instr, NOP);
    check("flush105_count", fetch_count, 32'd6);
    push(32'd105);
    step();
    check("at105_pc", ifc.if_pc, 32'd105);

    // Redirect to 87 while pc=105 is handshaking
    redirect_valid  = 1'b1;
    redirect_target = 32'd87;
    step();
    redirect_valid = 1'b0;
    check("flush87_valid", 32'(ifc.if_valid), 32'd0);
    check("flush87_count", fetch_count, 32'd7);
    push(32'd87);
    push(32'd88);
    step();
    check("at87_pc", ifc.if_pc, 32'd87);
    check("at87_instr", ifc.if_instr, 32'h0020_2303);
    step();

    // Wrap: redirect to 511 (upper target bits ignored)
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    push(32'd511);
    push(32'd0);
    push(32'd1);
    step();
    check("wrap_pc511", ifc.if_pc, 32'd511);
    check("wrap_addr0", imem_addr, 32'd0);
    step();
    check("wrap_pc0", ifc.if_pc, 32'd0);
    step();
    check("wrap_pc1", ifc.if_pc, 32'd1);

    // fetch_en=0 with a stalled valid slot, then drain
    ifc.if_ready = 1'b0;
    fetch_en     = 1'b0;
    step();
    check("hold_valid", 32'(ifc.if_valid), 32'd1);
    check("hold_pc", ifc.if_pc, 32'd1);
    check("hold_addr", imem_addr, 32'd2);
    ifc.if_ready = 1'b1;
    step();
    ifc.if_ready = 1'b0;
    check("drain_valid", 32'(ifc.if_valid), 32'd0);
    check("drain_addr", imem_addr, 32'd2);
    check("drain_count", fetch_count, 32'd12);
    step();
    check("frozen_addr", imem_addr, 32'd2);
    check("frozen_valid", 32'(ifc.if_valid), 32'd0);

    // Redirect while fetch is disabled still loads pc
    redirect_valid  = 1'b1;
    redirect_target = 32'd28;
    step();
    redirect_valid = 1'b0;
    check("redir_dis_addr", imem_addr, 32'd28);
    check("redir_dis_valid", 32'(ifc.if_valid), 32'd0);
    fetch_en     = 1'b1;
    ifc.if_ready = 1'b1;
    push(32'd28);
    push(32'd29);
    step();
    step();
    step();
    check("at30_pc", ifc.if_pc, 32'd30);
    check("pre_reset_count", fetch_count, 32'd14);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(ifc.if_valid), 32'd0);
    check("async_instr", ifc.if_instr, NOP);
    check("async_count", fetch_count, 32'd0);
    check("async_addr", imem_addr, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    push(32'd0);
    push(32'd1);
    step();
    check("post_reset_pc", ifc.if_pc, 32'd0);
    check("post_reset_valid", 32'(ifc.if_valid), 32'd1);
    check("post_reset_count", fetch_count, 32'd0);
    step();
    check("post_reset_pc1", ifc.if_pc, 32'd1);
    check("post_reset_count1", fetch_count, 32'd1);
    step();
    ifc.if_ready = 1'b0;
    fetch_en     = 1'b0;
    step();

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    n_cmp++;
    if (max_addr > 32'd511) begin
      n_bad++;
      $display("FAIL addr_range: got max %0d expected at most 511", max_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
